// File: rtl/combat_pkg.sv
// Shared definitions for the combat controller: FSM states, player ids,
// winner codes and a non-wrapping subtract helper.
package combat_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : 8'd0;
    endfunction

endpackage

// File: rtl/attack_cooldown.sv
// Per-player request front end: rising-edge detect, pending flag and a
// saturating lockout counter reloaded on every grant.
module attack_cooldown
    import combat_pkg::*;
#(
    parameter int COOLDOWN_CYCLES = 25_000_000,
    parameter int CD_W            = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic grant,
    input  logic lock,
    output logic pend,
    output logic ready
);

    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES);

    logic            r_req_q;
    logic            r_pend;
    logic [CD_W-1:0] r_cd;
    logic            w_rise;

    assign w_rise = req & ~r_req_q;
    assign ready  = (r_cd == '0);
    assign pend   = r_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_q <= 1'b0;
            r_pend  <= 1'b0;
            r_cd    <= '0;
        end else begin
            r_req_q <= req;
            if (grant) begin
                r_cd <= CD_LOAD;
            end else if (r_cd != '0) begin
                r_cd <= r_cd - CD_W'(1);
            end
            // Rises during lockout or after the round ends are dropped, not queued.
            if (grant) begin
                r_pend <= 1'b0;
            end else if (w_rise && ready && !lock) begin
                r_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/combat_arbiter.sv
// Combat controller: round-robin arbitration of player attacks, shield/health
// resolution with a one-cycle commit stage, and sticky end-of-round detection.
module combat_arbiter
    import combat_pkg::*;
#(
    parameter int HEALTH_INIT     = 15,
    parameter int SHIELD_INIT     = 15,
    parameter int HIT_DAMAGE      = 3,
    parameter int SHIELD_COST     = 1,
    parameter int COOLDOWN_CYCLES = 25_000_000,
    parameter int CD_W            = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p1_attack_req,
    input  logic       p2_attack_req,
    input  logic       p1_shield_up,
    input  logic       p2_shield_up,
    input  logic       in_range,
    output logic [7:0] p1_health,
    output logic [7:0] p1_shield,
    output logic [7:0] p2_health,
    output logic [7:0] p2_shield,
    output logic       p1_ack,
    output logic       p2_ack,
    output logic       p1_hit,
    output logic       p2_hit,
    output logic       blocked,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [7:0] HEALTH_RST = 8'(HEALTH_INIT);
    localparam logic [7:0] SHIELD_RST = 8'(SHIELD_INIT);
    localparam logic [7:0] DMG        = 8'(HIT_DAMAGE);
    localparam logic [7:0] COST       = 8'(SHIELD_COST);

    state_t     r_state, w_state_next;
    logic       r_grant, r_last_grant;
    logic [1:0] w_req, w_pend, w_ready, w_req_ok, w_gnt;
    logic       w_lock;

    logic [7:0] r_p1_health, r_p1_shield, r_p2_health, r_p2_shield;
    logic       r_p1_hit, r_p2_hit, r_blocked, r_game_over;
    winner_t    r_winner;

    logic       r_cm_hit, r_cm_block, r_cm_kill, r_cm_def;
    logic [7:0] r_cm_health, r_cm_shield;

    logic [7:0] w_def_health, w_def_shield, w_new_health, w_new_shield;
    logic       w_def_guard, w_do_block, w_do_hit, w_kill;

    assign w_req    = {p2_attack_req, p1_attack_req};
    assign w_lock   = (r_state == OVER);
    assign w_req_ok = w_pend & w_ready;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cd
        attack_cooldown #(
            .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
            .CD_W           (CD_W)
        ) u_cd (
            .clk  (clk),
            .reset(reset),
            .req  (w_req[gi]),
            .grant(w_gnt[gi]),
            .lock (w_lock),
            .pend (w_pend[gi]),
            .ready(w_ready[gi])
        );
    end

    // Defender is always the player that was not granted.
    assign w_def_health = (r_grant == P1) ? r_p2_health : r_p1_health;
    assign w_def_shield = (r_grant == P1) ? r_p2_shield : r_p1_shield;
    assign w_def_guard  = (r_grant == P1) ? p2_shield_up : p1_shield_up;
    assign w_do_block   = in_range & w_def_guard & (w_def_shield >= COST);
    assign w_do_hit     = in_range & ~w_do_block;
    assign w_new_health = sat_sub(w_def_health, DMG);
    assign w_new_shield = w_def_shield - COST;
    assign w_kill       = w_do_hit && (w_new_health == 8'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= P1;
            r_last_grant <= P2;
        end else begin
            r_state <= w_state_next;
            if (w_gnt != 2'b00) begin
                r_grant      <= w_gnt[P2];
                r_last_grant <= w_gnt[P2];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gnt        = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_req_ok[P1] && (!w_req_ok[P2] || r_last_grant == P2)) begin
                    w_gnt[P1]    = 1'b1;
                    w_state_next = APPLY;
                end else if (w_req_ok[P2]) begin
                    w_gnt[P2]    = 1'b1;
                    w_state_next = APPLY;
                end
            end
            APPLY:   w_state_next = w_kill ? OVER : IDLE;
            OVER:    w_state_next = OVER;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        p1_ack = 1'b0;
        p2_ack = 1'b0;
        if (r_state == APPLY) begin
            p1_ack = (r_grant == P1);
            p2_ack = (r_grant == P2);
        end
    end

    // APPLY decisions are captured here and land in the register bank one
    // cycle later, so the new value and its pulse appear together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cm_hit    <= 1'b0;
            r_cm_block  <= 1'b0;
            r_cm_kill   <= 1'b0;
            r_cm_def    <= P2;
            r_cm_health <= 8'd0;
            r_cm_shield <= 8'd0;
        end else begin
            r_cm_hit    <= (r_state == APPLY) && w_do_hit;
            r_cm_block  <= (r_state == APPLY) && w_do_block;
            r_cm_kill   <= (r_state == APPLY) && w_kill;
            r_cm_def    <= ~r_grant;
            r_cm_health <= w_new_health;
            r_cm_shield <= w_new_shield;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p1_health <= HEALTH_RST;
            r_p2_health <= HEALTH_RST;
            r_p1_shield <= SHIELD_RST;
            r_p2_shield <= SHIELD_RST;
            r_p1_hit    <= 1'b0;
            r_p2_hit    <= 1'b0;
            r_blocked   <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= WIN_NONE;
        end else begin
            r_p1_hit  <= r_cm_hit && (r_cm_def == P1);
            r_p2_hit  <= r_cm_hit && (r_cm_def == P2);
            r_blocked <= r_cm_block;
            if (r_cm_hit) begin
                if (r_cm_def == P1) r_p1_health <= r_cm_health;
                else                r_p2_health <= r_cm_health;
            end
            if (r_cm_block) begin
                if (r_cm_def == P1) r_p1_shield <= r_cm_shield;
                else                r_p2_shield <= r_cm_shield;
            end
            if (r_cm_kill) begin
                r_game_over <= 1'b1;
                r_winner    <= (r_cm_def == P2) ? WIN_P1 : WIN_P2;
            end
        end
    end

    assign p1_health = r_p1_health;
    assign p1_shield = r_p1_shield;
    assign p2_health = r_p2_health;
    assign p2_shield = r_p2_shield;
    assign p1_hit    = r_p1_hit;
    assign p2_hit    = r_p2_hit;
    assign blocked   = r_blocked;
    assign game_over = r_game_over;
    assign winner    = r_winner;

endmodule

// File: tb/tb_combat_arbiter.sv
// Directed bench for combat_arbiter with a short cooldown; outputs are
// sampled on the falling edge, away from the active edge.
module tb_combat_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       p1_attack_req, p2_attack_req;
    logic       p1_shield_up, p2_shield_up, in_range;
    logic [7:0] p1_health, p1_shield, p2_health, p2_shield;
    logic       p1_ack, p2_ack, p1_hit, p2_hit, blocked, game_over;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;
    int cnt;

    combat_arbiter #(
        .HEALTH_INIT    (15),
        .SHIELD_INIT    (15),
        .HIT_DAMAGE     (3),
        .SHIELD_COST    (1),
        .COOLDOWN_CYCLES(4),
        .CD_W           (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .p1_attack_req(p1_attack_req),
        .p2_attack_req(p2_attack_req),
        .p1_shield_up (p1_shield_up),
        .p2_shield_up (p2_shield_up),
        .in_range     (in_range),
        .p1_health    (p1_health),
        .p1_shield    (p1_shield),
        .p2_health    (p2_health),
        .p2_shield    (p2_shield),
        .p1_ack       (p1_ack),
        .p2_ack       (p2_ack),
        .p1_hit       (p1_hit),
        .p2_hit       (p2_hit),
        .blocked      (blocked),
        .game_over    (game_over),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle request pulse; the rising edge is sampled at the next posedge.
    task automatic fire(input logic a1, input logic a2);
        p1_attack_req = a1;
        p2_attack_req = a2;
        @(negedge clk);
        p1_attack_req = 1'b0;
        p2_attack_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        p1_attack_req = 1'b0;
        p2_attack_req = 1'b0;
        p1_shield_up = 1'b0;
        p2_shield_up = 1'b0;
        in_range = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    initial begin
        reset = 1'b1;
        p1_attack_req = 1'b0;
        p2_attack_req = 1'b0;
        p1_shield_up = 1'b0;
        p2_shield_up = 1'b0;
        in_range = 1'b0;
        step(3);
        chk("rst_held_p1_health", p1_health, 15);
        reset = 1'b0;
        step(1);
        chk("rst_p1_health", p1_health, 15);
        chk("rst_p2_health", p2_health, 15);
        chk("rst_p1_shield", p1_shield, 15);
        chk("rst_p2_shield", p2_shield, 15);
        chk("rst_game_over", game_over, 0);
        chk("rst_winner", winner, 0);
        chk("rst_pulses", {p1_ack, p2_ack, p1_hit, p2_hit, blocked}, 0);
        $display("reset: checks=%0d", checks);

        // Single unblocked hit, dropped re-press inside cooldown, re-press after.
        in_range = 1'b1;
        fire(1, 0);
        chk("a_pend_no_ack", p1_ack, 0);
        step;
        chk("a_p1_ack", p1_ack, 1);
        chk("a_p2_ack", p2_ack, 0);
        step;
        chk("a_ack_one_cycle", p1_ack, 0);
        chk("a_health_not_yet", p2_health, 15);
        step;
        chk("a_p2_health", p2_health, 12);
        chk("a_p2_hit", p2_hit, 1);
        chk("a_p1_health", p1_health, 15);
        fire(1, 0);
        chk("a_hit_one_cycle", p2_hit, 0);
        cnt = 0;
        repeat (4) begin
            step;
            if (p1_ack) cnt++;
        end
        chk("a_repress_dropped", cnt, 0);
        fire(1, 0);
        step;
        chk("a_press_after_cd", p1_ack, 1);
        step(2);
        chk("a_p2_health_2", p2_health, 9);
        $display("single hit: checks=%0d", checks);
        step(6);

        // Ties: P1 wins the first, then last_grant decides.
        do_reset();
        in_range = 1'b1;
        fire(1, 1);
        step;
        chk("tie1_p1_first", p1_ack, 1);
        chk("tie1_p2_waits", p2_ack, 0);
        step(2);
        chk("tie1_p2_second", p2_ack, 1);
        chk("tie1_p1_no_ack", p1_ack, 0);
        chk("tie1_p2_health", p2_health, 12);
        step(2);
        chk("tie1_p1_health", p1_health, 12);
        chk("tie1_p1_hit", p1_hit, 1);
        step(6);
        fire(1, 0);
        step(3);
        chk("solo_p2_health", p2_health, 9);
        step(6);
        // last grant was P1, so P2 takes this tie
        fire(1, 1);
        step;
        chk("tie2_p2_first", p2_ack, 1);
        chk("tie2_p1_waits", p1_ack, 0);
        step(2);
        chk("tie2_p1_second", p1_ack, 1);
        chk("tie2_p1_health", p1_health, 9);
        step(2);
        chk("tie2_p2_health", p2_health, 6);
        $display("ties: checks=%0d", checks);
        step(6);

        // Shield absorption down to zero shield, then damage goes through.
        do_reset();
        in_range = 1'b1;
        p2_shield_up = 1'b1;
        fire(1, 0);
        step(3);
        chk("blk_p2_shield", p2_shield, 14);
        chk("blk_p2_health", p2_health, 15);
        chk("blk_pulse", blocked, 1);
        chk("blk_no_hit", p2_hit, 0);
        step(6);
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            fire(1, 0);
            step(3);
            if (blocked) cnt++;
            step(6);
        end
        chk("blk_count", cnt, 14);
        chk("blk_shield_empty", p2_shield, 0);
        chk("blk_health_kept", p2_health, 15);
        fire(1, 0);
        step(3);
        chk("empty_p2_health", p2_health, 12);
        chk("empty_p2_hit", p2_hit, 1);
        chk("empty_no_block", blocked, 0);
        chk("empty_shield_stays", p2_shield, 0);
        $display("shield: checks=%0d", checks);
        step(6);

        // Whiff: ack but no change, cooldown still loaded.
        in_range = 1'b0;
        p2_shield_up = 1'b0;
        fire(0, 1);
        step;
        chk("whiff_p2_ack", p2_ack, 1);
        step(2);
        chk("whiff_p1_health", p1_health, 15);
        chk("whiff_p1_shield", p1_shield, 15);
        chk("whiff_no_pulse", {p1_hit, p2_hit, blocked}, 0);
        chk("whiff_p2_health", p2_health, 12);
        fire(0, 1);
        cnt = 0;
        repeat (4) begin
            step;
            if (p2_ack) cnt++;
        end
        chk("whiff_cd_loaded", cnt, 0);
        step(2);
        fire(0, 1);
        step;
        chk("whiff_after_cd", p2_ack, 1);
        $display("whiff: checks=%0d", checks);
        step(6);

        // Knockout in five hits, then frozen until reset.
        do_reset();
        in_range = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fire(1, 0);
            step;
            chk("ko_ack", p1_ack, 1);
            step(2);
            chk("ko_p2_health", p2_health, 15 - 3 * (i + 1));
            chk("ko_game_over", game_over, (i == 4));
            step(6);
        end
        chk("ko_winner", winner, 1);
        fire(0, 1);
        cnt = 0;
        repeat (4) begin
            step;
            if (p1_ack || p2_ack) cnt++;
        end
        fire(1, 0);
        repeat (4) begin
            step;
            if (p1_ack || p2_ack) cnt++;
        end
        chk("ko_req_ignored", cnt, 0);
        chk("ko_p1_frozen", p1_health, 15);
        chk("ko_p2_frozen", p2_health, 0);
        chk("ko_sticky", game_over, 1);
        reset = 1'b1;
        #1;
        chk("ko_rst_game_over", game_over, 0);
        chk("ko_rst_winner", winner, 0);
        chk("ko_rst_p2_health", p2_health, 15);
        $display("knockout: checks=%0d", checks);
        step;
        reset = 1'b0;
        step(2);

        // Reset during APPLY: nothing commits, cooldown also cleared.
        in_range = 1'b1;
        fire(1, 0);
        step;
        chk("mid_ack", p1_ack, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ack", p1_ack, 0);
        chk("mid_rst_health", p2_health, 15);
        @(negedge clk);
        reset = 1'b0;
        step(2);
        chk("mid_no_commit", p2_health, 15);
        chk("mid_no_hit", p2_hit, 0);
        fire(1, 0);
        step;
        chk("mid_cd_cleared", p1_ack, 1);
        $display("mid-apply reset: checks=%0d", checks);
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
